// File: rtl/iq_repacker2_pkg.sv
// Shared DSP-stream definitions for the IQ pair repacker: default widths,
// FIFO depth and the packet-framing FSM encoding.
package iq_repacker2_pkg;

  localparam int unsigned DATA_W_DEF     = 24;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    WAIT_SOP = 1'b0,
    WAIT_EOP = 1'b1
  } rp_state_e;

endpackage

// File: rtl/iq_repacker2_pair_fifo.sv
// Show-ahead FIFO holding reassembled {ch1, ch2} pairs with an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module iq_pair_fifo
  import iq_repacker2_pkg::*;
#(
  parameter int unsigned WIDTH = 2 * DATA_W_DEF,
  parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != DEPTH_C);
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // Storage is not reset; the head is forced to zero whenever nothing is stored.
  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/iq_repacker2.sv
// Reassembles 2-beat sop/eop packets into parallel channel-1/channel-2 pairs,
// counting framing errors with a saturating 8-bit counter.
module iq_repacker2
  import iq_repacker2_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  input  logic                          in_sop,
  input  logic                          in_eop,
  output logic                          in_ready,
  output logic [DATA_W-1:0]             out_data_1,
  output logic [DATA_W-1:0]             out_data_2,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    err_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  rp_state_e         state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [7:0]        err_q, err_d;
  logic              accept, push, err_hit;
  logic [2*DATA_W-1:0] head;

  assign in_ready = (fifo_count < DEPTH_C);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    push    = 1'b0;
    err_hit = 1'b0;
    if (accept) begin
      if (state_q == WAIT_SOP) begin
        if (in_sop && !in_eop) begin
          hold_d  = in_data;
          state_d = WAIT_EOP;
        end else begin
          err_hit = 1'b1;
        end
      end else begin
        if (in_sop) begin
          // Restart: the new sop replaces the orphaned channel-1 word.
          err_hit = 1'b1;
          hold_d  = in_data;
        end else if (in_eop) begin
          push    = 1'b1;
          state_d = WAIT_SOP;
        end else begin
          err_hit = 1'b1;
          hold_d  = '0;
          state_d = WAIT_SOP;
        end
      end
    end
    err_d = (err_hit && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_SOP;
      hold_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
    end
  end

  iq_pair_fifo #(
    .WIDTH (2 * DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pair_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data ({hold_q, in_data}),
    .pop       (out_ready),
    .head_data (head),
    .count     (fifo_count)
  );

  assign out_valid  = (fifo_count != '0);
  assign out_data_1 = head[2*DATA_W-1:DATA_W];
  assign out_data_2 = head[DATA_W-1:0];
  assign err_count  = err_q;

endmodule

// File: tb/tb_iq_repacker2.sv
// Directed bench for iq_repacker2: framing, backpressure, ordering,
// error saturation and mid-packet reset.
module tb_iq_repacker2;

  localparam int unsigned DW    = 24;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] in_data;
  logic          in_valid, in_sop, in_eop, in_ready;
  logic [DW-1:0] out_data_1, out_data_2;
  logic          out_valid, out_ready;
  logic [2:0]    fifo_count;
  logic [7:0]    err_count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [2*DW-1:0] got[$];

  always #5 clk = ~clk;

  iq_repacker2 #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .in_ready   (in_ready),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .err_count  (err_count)
  );

  // Record every pair the consumer actually pops.
  always @(posedge clk) begin
    if (reset_n && out_valid && out_ready) got.push_back({out_data_1, out_data_2});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    got.delete();
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic s, input logic e);
    int unsigned waited = 0;
    @(negedge clk);
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("beat_accept_timeout", 64'd0, 64'd1);
    end else begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2*DW-1:0] exp_pairs [5];
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset values while reset is held
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data_1", out_data_1, 0);
    chk("rst_out_data_2", out_data_2, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_err_count", err_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single packet, one-cycle latency, one-cycle out_valid
    out_ready = 1'b1;
    send_beat(24'h000123, 1'b1, 1'b0);
    chk("sop_no_output", out_valid, 0);
    send_beat(24'hFFFE00, 1'b0, 1'b1);
    chk("pair_valid", out_valid, 1);
    chk("pair_ch1", out_data_1, 24'h000123);
    chk("pair_ch2", out_data_2, 24'hFFFE00);
    @(posedge clk);
    #1;
    chk("pair_valid_one_cycle", out_valid, 0);
    chk("pair_count_back", fifo_count, 0);
    chk("pair_popped_once", got.size(), 1);

    // Backpressure: fill the FIFO, stall a fifth packet, then drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      exp_pairs[i] = {24'hA00000 | 24'(i), 24'h5B0000 | 24'(i)};
    for (int i = 0; i < 4; i++) begin
      send_beat(exp_pairs[i][2*DW-1:DW], 1'b1, 1'b0);
      send_beat(exp_pairs[i][DW-1:0], 1'b0, 1'b1);
    end
    chk("full_count", fifo_count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_head_ch1", out_data_1, 24'hA00000);
    fork
      begin
        send_beat(exp_pairs[4][2*DW-1:DW], 1'b1, 1'b0);
        send_beat(exp_pairs[4][DW-1:0], 1'b0, 1'b1);
      end
      begin
        repeat (5) @(negedge clk);
        chk("stall_count", fifo_count, 4);
        chk("stall_in_ready", in_ready, 0);
        out_ready = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    chk("drain_count", fifo_count, 0);
    chk("drain_pairs", got.size(), 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("drain_order_%0d", i), (got.size() > i) ? got[i] : '0, exp_pairs[i]);

    // Framing errors: lone eop, then sop A, sop B, eop C
    do_reset();
    out_ready = 1'b1;
    send_beat(24'h0000EE, 1'b0, 1'b1);
    send_beat(24'h111111, 1'b1, 1'b0);
    send_beat(24'h222222, 1'b1, 1'b0);
    send_beat(24'h333333, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("frame_err_count", err_count, 2);
    chk("frame_pairs", got.size(), 1);
    chk("frame_pair_bc", (got.size() > 0) ? got[0] : '0, {24'h222222, 24'h333333});

    // Mid-packet plain beat aborts the packet; the following eop is then orphaned
    do_reset();
    out_ready = 1'b1;
    send_beat(24'h444444, 1'b1, 1'b0);
    send_beat(24'h555555, 1'b0, 1'b0);
    chk("abort_err", err_count, 1);
    send_beat(24'h666666, 1'b0, 1'b1);
    send_beat(24'h800007, 1'b1, 1'b0);
    send_beat(24'h000008, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("abort_err_total", err_count, 2);
    chk("abort_pairs", got.size(), 1);
    chk("abort_pair", (got.size() > 0) ? got[0] : '0, {24'h800007, 24'h000008});

    // Saturation of the error counter
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_beat(24'(i), 1'b0, 1'b0);
      if (i == 253) chk("sat_254", err_count, 254);
      if (i == 254) chk("sat_255", err_count, 255);
    end
    chk("sat_hold", err_count, 255);
    chk("sat_no_pairs", got.size(), 0);

    // Reset in the middle of a packet
    do_reset();
    out_ready = 1'b0;
    send_beat(24'h0ABCDE, 1'b1, 1'b0);
    send_beat(24'h012345, 1'b0, 1'b1);
    send_beat(24'h777777, 1'b0, 1'b0);
    send_beat(24'h135790, 1'b1, 1'b0);
    chk("pre_rst_count", fifo_count, 1);
    chk("pre_rst_err", err_count, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data_1", out_data_1, 0);
    chk("mid_rst_out_data_2", out_data_2, 0);
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    got.delete();
    send_beat(24'h246802, 1'b0, 1'b1);
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_err", err_count, 1);
    chk("post_rst_pairs", got.size(), 0);
    chk("post_rst_count", fifo_count, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/iq_repacker2.md
IQ_REPACKER2 -- requirements
Module: iq_repacker2

Interface
REQ-001 Parameter DATA_W, default 24, sample word width.
REQ-002 Parameter FIFO_DEPTH, default 4, pair-FIFO depth; power of two, at least 2.
REQ-003 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 Port reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port in_data, input, DATA_W, signed stream sample; channel 1 on the sop beat, channel 2 on the eop beat.
REQ-006 Ports in_valid, in_sop and in_eop, input, 1 each, beat qualifier and packet delimiters.
REQ-007 Port in_ready, output, 1, beat accepted when in_valid and in_ready are both high.
REQ-008 Ports out_data_1 and out_data_2, output, DATA_W each, reassembled channel-1/channel-2 pair.
REQ-009 Port out_valid, output, 1, pair present at the FIFO head.
REQ-010 Port out_ready, input, 1, consumer pops the head when out_valid and out_ready are both high.
REQ-011 Port fifo_count, output, clog2(FIFO_DEPTH)+1, number of stored pairs.
REQ-012 Port err_count, output, 8, saturating count of framing errors.

Function
REQ-013 Block is downstream of the 2-channel serializer/filter chain; it turns 2-beat sop/eop packets back into parallel channel pairs.
REQ-014 in_ready = (fifo_count < FIFO_DEPTH); purely combinational from registered count.
REQ-015 FSM states: WAIT_SOP and WAIT_EOP; reset state is WAIT_SOP; no transition without an accepted beat.
REQ-016 WAIT_SOP, accepted beat sop=1, eop=0: latch in_data into hold register; go to WAIT_EOP.
REQ-017 WAIT_SOP, accepted beat with sop=0, or with sop=1 and eop=1: drop beat; err_count+1; stay in WAIT_SOP.
REQ-018 WAIT_EOP, accepted beat sop=0, eop=1: push {hold, in_data} into FIFO; go to WAIT_SOP.
REQ-019 WAIT_EOP, accepted beat sop=1: err_count+1; discard old hold; latch new beat as channel 1; stay in WAIT_EOP.
REQ-020 WAIT_EOP, accepted beat sop=0, eop=0: err_count+1; drop beat and hold; go to WAIT_SOP.
REQ-021 err_count saturates at 255; at most one increment per cycle.
REQ-022 FIFO is show-ahead: out_valid = (fifo_count != 0); out_data_1/out_data_2 show the head pair.
REQ-023 Latency: a pair is on the outputs with out_valid=1 in the cycle after its eop beat is accepted, provided the FIFO was empty.
REQ-024 Push and pop in the same cycle leave fifo_count unchanged; order is strictly FIFO.
REQ-025 When full, in_ready=0; a sop beat is not accepted while full, even though it would not push.
REQ-026 Popping when empty, or out_ready held with out_valid=0, has no effect.
REQ-027 Read and write pointers wrap modulo FIFO_DEPTH without a gap or a duplicated pair.
REQ-028 Data is bit-exact; no sign extension, rounding or reordering within a pair.

Reset
REQ-029 On reset_n low, asynchronously: state=WAIT_SOP, fifo_count=0, pointers=0, err_count=0, out_valid=0.
REQ-030 On reset_n low, out_data_1=0, out_data_2=0 and the hold register is 0.
REQ-031 Reset mid-packet discards the held channel-1 word; the next accepted beat is evaluated in WAIT_SOP.
REQ-032 in_ready is 1 in the first cycle after reset deassertion.

Structure
REQ-033 DATA_W default, FIFO_DEPTH default and the FSM state encodings live in the shared DSP-stream package/include.
REQ-034 Storage is one sub-module, iq_pair_fifo (2*DATA_W wide, show-ahead, count output); the FSM and error counter stay in iq_repacker2.

Verification
REQ-035 Stream beats 0x000123 (sop) then 0xFFFE00 (eop), out_ready=1 -> next cycle out_data_1=0x000123, out_data_2=0xFFFE00, out_valid=1 for exactly 1 cycle.
REQ-036 Hold out_ready=0 and send 5 valid packets -> 4 pairs stored, fifo_count=4, in_ready=0; fifth packet is stalled, not lost.
REQ-037 Set out_ready=1 after REQ-036 -> 5 pairs emerge in order and fifo_count returns to 0.
REQ-038 Send an eop-only beat, then sop A, sop B, eop C -> err_count=2; the only output pair is (B,C).
REQ-039 Send 300 lone non-sop beats -> err_count=255 and stays at 255.
REQ-040 Assert reset_n low after a sop beat and then send an eop beat -> no pair is output, err_count=1, and all outputs are at their reset values during reset.
